systolic_edge_feeder: RTL and testbench
=======================================

// Module: systolic_edge_feeder
// PURPOSE
//  Upstream stage of the systolic PE array. Accepts one N-lane vector per beat
//  (row slice of A or column slice of B) via valid/ready. Delays lane i by i
//  cycles so operands meet diagonally, and drives the array edge a_in/v_a_in
//  (or b_in/v_b_in) per lane. Sequences each tile: PE clear pulse, K feed
//  beats, skew flush, done.
//  Instantiate twice (A edge, B edge) with common start/k_len and lockstep
//  s_valid. Only the A instance's pe_clear is used.
// PARAMETERS
//  N     4    lanes (array rows for A, columns for B)
//  DW    16   signed operand width per lane (matches PE DW)
//  K_MAX 256  max reduction length per tile
//  KW    $clog2(K_MAX+1)  width of k_len / beat counter
// PORTS
//  clk         in   1      clock
//  rstn        in   1      asynchronous active-low reset
//  start       in   1      tile start request, sampled only in IDLE
//  k_len       in   KW     beats in tile (0..K_MAX), latched with start
//  busy        out  1      1 in every state except IDLE
//  done        out  1      1-cycle pulse at tile end
//  pe_clear    out  1      1-cycle synchronous accumulator clear to array
//  s_valid     in   1      input vector valid
//  s_ready     out  1      1 only in FEED
//  s_data      in   N*DW   lane i = s_data[i*DW +: DW], signed
//  edge_data   out  N*DW   skewed lane data to array edge
//  edge_valid  out  N      per-lane valid to array edge
// BEHAVIOUR
//  Reset: FSM=IDLE, all skew regs, counter, edge_data, edge_valid 0.
//   busy, done, pe_clear and s_ready all 0. Reset mid-tile aborts immediately.
//  FSM (all outputs registered/Moore; one transition per rising edge):
//   IDLE : start=1 -> latch k_len -> CLEAR.
//   CLEAR: pe_clear=1 one cycle. k_len==0 -> DONE; else -> FEED.
//   FEED : s_ready=1. Accept = s_valid&s_ready.
//          Accept on the k_len-th beat -> FLUSH.
//   FLUSH: N cycles, counter-driven, no accepts -> DONE.
//   DONE : done=1 one cycle -> IDLE.
//  Skew: lane i is a chain of i+1 regs (data + valid) that shifts every cycle.
//   An accept at edge e puts lane i on edge_data/edge_valid[i] for the
//   cycle after edge e+i. Lane N-1's last beat shows in the last FLUSH cycle.
//   Cycles without accept inject valid=0, data=0 into stage 0 of every lane.
//   A bubble therefore travels the same diagonal as data.
//  Data passes unmodified (no sign/width change); invalid slots carry 0.
//  Beat counter counts accepts only. Never exceeds latched k_len.
//  start/k_len while busy: ignored, latched k_len unchanged.
//  No backpressure from array: edge outputs shift every cycle unconditionally.
//  Both instances must see identical accept cycles.
//   Upstream joint-gates s_valid; a bubble on one side only misaligns MACs.
//  Timing, no bubbles, start sampled at edge 0:
//   pe_clear after edge 0. First accept at edge 2.
//   done visible after edge k_len+N+1. k_len==0: done after edge 1.
//   Each input bubble adds 1 cycle.
// TESTING  (N=4, DW=16)
//  Reset: rstn=0 -> edge_valid=0, edge_data=0, busy/done/pe_clear/s_ready=0.
//  start,k_len=3, s_valid=1, s_data lanes {1,2,3,4},{5,6,7,8},{9,A,B,C}:
//   lane0 shows 1,5,9 at cycles 3-5; lane3 shows 4,8,C at cycles 6-8.
//   done pulses at cycle 9 (after edge 8).
//  Bubble: same stream, s_valid=0 at second FEED cycle:
//   every lane has one valid=0 slot between beats 1 and 2; done 1 cycle later.
//  k_len=0: pe_clear after edge0, done after edge1, s_ready never 1.
//  start pulsed again with k_len=7 during FEED -> ignored; tile still 3 beats.
//  rstn low mid-FEED -> next cycle IDLE, all outputs 0.
//   Fresh start then behaves as the k_len=3 case.
//  Signed pass-through: lanes 0x8000/0x7FFF/0xFFFF/0x0000 emerge bit-exact.

Source files
------------

// File: rtl/systolic_edge_feeder_if.sv
// Input vector stream into the systolic edge feeder: one N-lane vector per beat
// with a valid/ready handshake. Lane i occupies s_data[i*DW +: DW].
interface systolic_edge_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 16
) ();
  logic            s_valid;
  logic            s_ready;
  logic [N*DW-1:0] s_data;

  // Upstream producer side
  modport master (output s_valid, output s_data, input s_ready);
  // Feeder side
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for one side (A or B) of the systolic PE array. Accepts one
// N-lane vector per beat, delays lane i by i cycles so operands meet on the
// diagonal, and sequences a tile: PE clear pulse, K feed beats, skew flush,
// done pulse. Two instances (A and B edges) run in lockstep.
module systolic_edge_feeder #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_clear,
  systolic_edge_feeder_if.slave  s_if,
  output logic [N*DW-1:0]        edge_data,
  output logic [N-1:0]           edge_valid
);

  localparam int FW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k_len;
  logic [KW-1:0] r_beat_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_pe_clear;
  logic          r_s_ready;

  logic          w_accept;
  logic [KW-1:0] w_beat_next;

  // ready is a registered Moore output, so an accept is purely valid & ready
  assign w_accept    = s_if.s_valid & r_s_ready;
  assign w_beat_next = r_beat_cnt + 1'b1;

  assign busy        = r_busy;
  assign done        = r_done;
  assign pe_clear    = r_pe_clear;
  assign s_if.s_ready = r_s_ready;

  // Tile sequencer; every output is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pe_clear  <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so the
      // order of statements below never changes which value another reads.
      r_done     <= 1'b0;
      r_pe_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k_len    <= k_len;
            r_state    <= S_CLEAR;
            r_pe_clear <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_beat_cnt <= '0;
          if (r_k_len == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_FEED;
            r_s_ready <= 1'b1;
          end
        end
        S_FEED: begin
          if (w_accept) begin
            r_beat_cnt <= w_beat_next;
            if (w_beat_next == r_k_len) begin
              r_state     <= S_FLUSH;
              r_s_ready   <= 1'b0;
              r_flush_cnt <= '0;
            end
          end
        end
        S_FLUSH: begin
          // N cycles let the last beat walk down to lane N-1
          if (r_flush_cnt == FW'(N - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane skew chains: lane i has i+1 stages and shifts every cycle
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] r_data [0:i];
    logic [i:0]    r_vld;

    // Stage 0 takes the accepted lane value or a zero bubble; later stages shift
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        // NOTE: the skew stages are reset, unlike a plain storage array,
        // because an invalid edge slot must read as 0 right after reset.
        for (int j = 0; j <= i; j++) r_data[j] <= '0;
        r_vld <= '0;
      end else begin
        r_data[0] <= w_accept ? s_if.s_data[i*DW +: DW] : '0;
        r_vld[0]  <= w_accept;
        for (int j = 1; j <= i; j++) begin
          r_data[j] <= r_data[j-1];
          r_vld[j]  <= r_vld[j-1];
        end
      end
    end

    assign edge_data[i*DW +: DW] = r_data[i];
    assign edge_valid[i]         = r_vld[i];
  end

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder (N=4, DW=16). Each tile is run
// cycle by cycle; after every rising edge the control outputs and all edge
// lanes are compared against values derived from the expected accept edges.
module tb_systolic_edge_feeder;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int KW = 9;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            pe_clear;
  logic [N*DW-1:0] edge_data;
  logic [N-1:0]    edge_valid;

  systolic_edge_feeder_if #(.N(N), .DW(DW)) s_if ();

  systolic_edge_feeder #(.N(N), .DW(DW), .K_MAX(256), .KW(KW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .pe_clear   (pe_clear),
    .s_if       (s_if),
    .edge_data  (edge_data),
    .edge_valid (edge_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N*DW-1:0] vec [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Everything the array and upstream see must be quiet
  task automatic check_quiet(input string tag);
    check({tag, " busy"},       32'(busy),        32'd0);
    check({tag, " done"},       32'(done),        32'd0);
    check({tag, " pe_clear"},   32'(pe_clear),    32'd0);
    check({tag, " s_ready"},    32'(s_if.s_ready), 32'd0);
    check({tag, " edge_valid"}, 32'(edge_valid),  32'd0);
    check({tag, " edge_data_lo"}, edge_data[31:0],  32'd0);
    check({tag, " edge_data_hi"}, edge_data[63:32], 32'd0);
  endtask

  // Run one tile. Start is presented for edge 0. Beat b uses vec[base+b];
  // vec[base+k] is filler that must never be accepted. bubble_edge drops
  // s_valid at that edge, restart_edge pulses start with k_len=7 there,
  // abort_edge returns right after observing that edge.
  task automatic run_tile(input string name, input int k, input int base,
                          input int bubble_edge, input int restart_edge,
                          input int abort_edge);
    int acc[$];
    int e;
    int done_edge;
    int rdy_hi;
    int nacc;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [N*DW-1:0] beat;

    e = 2;
    for (int b = 0; b < k; b++) begin
      if (e == bubble_edge) e++;
      acc.push_back(e);
      e++;
    end
    done_edge = (k == 0) ? 1 : acc[k-1] + N;
    rdy_hi    = (k == 0) ? -1 : acc[k-1] - 1;

    start     = 1'b1;
    k_len     = KW'(k);
    s_if.s_valid = (bubble_edge != 0);
    s_if.s_data  = vec[base];

    for (int t = 0; t <= done_edge + 2; t++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s t%0d busy", name, t),     32'(busy),         32'(t <= done_edge));
      check($sformatf("%s t%0d pe_clear", name, t), 32'(pe_clear),     32'(t == 0));
      check($sformatf("%s t%0d done", name, t),     32'(done),         32'(t == done_edge));
      check($sformatf("%s t%0d s_ready", name, t),  32'(s_if.s_ready), 32'(t >= 1 && t <= rdy_hi));
      for (int i = 0; i < N; i++) begin
        exp_v = 1'b0;
        exp_d = '0;
        for (int b = 0; b < k; b++) begin
          if (acc[b] + i == t) begin
            beat  = vec[base + b];
            exp_v = 1'b1;
            exp_d = beat[i*DW +: DW];
          end
        end
        check($sformatf("%s t%0d lane%0d valid", name, t, i), 32'(edge_valid[i]), 32'(exp_v));
        check($sformatf("%s t%0d lane%0d data", name, t, i),
              32'(edge_data[i*DW +: DW]), 32'(exp_d));
      end
      if (t == abort_edge) return;

      nacc = 0;
      for (int b = 0; b < k; b++) if (acc[b] <= t) nacc++;
      start        = (t + 1 == restart_edge);
      k_len        = (restart_edge >= 0 && t + 1 >= restart_edge) ? KW'(7) : KW'(k);
      s_if.s_valid = (t + 1 != bubble_edge);
      s_if.s_data  = vec[base + nacc];
    end
    start        = 1'b0;
    s_if.s_valid = 1'b0;
  endtask

  initial begin
    vec[0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    vec[1] = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    vec[2] = {16'h000C, 16'h000B, 16'h000A, 16'h0009};
    vec[3] = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    vec[4] = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    vec[5] = {16'h1357, 16'h2468, 16'hAAAA, 16'h5555};
    vec[6] = '0;
    vec[7] = '0;

    rstn         = 1'b0;
    start        = 1'b0;
    k_len        = '0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    #12;
    check_quiet("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Back-to-back beats, then one bubble, then an empty tile
    run_tile("k3",     3, 0, -1, -1, -1);
    run_tile("bubble", 3, 0,  3, -1, -1);
    run_tile("k0",     0, 0, -1, -1, -1);

    // start with k_len=7 while feeding must not relatch
    run_tile("restart", 3, 0, -1, 3, -1);

    // Asynchronous reset in the middle of FEED, then a fresh tile
    run_tile("abort", 3, 0, -1, -1, 3);
    rstn         = 1'b0;
    start        = 1'b0;
    s_if.s_valid = 1'b1;
    #1;
    check_quiet("abort_async");
    @(posedge clk);
    #1;
    check_quiet("abort_held");
    rstn = 1'b1;
    run_tile("after_rst", 3, 0, -1, -1, -1);

    // Extreme signed values pass through bit-exact
    run_tile("signed", 1, 4, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the clocked sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
